// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives instruction memory,
// presents instr/pc_4 to execute and commits the returned next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_result,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic [31:0] fetch_count,
  output logic        misaligned
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic        take;
  logic        commit;
  logic        bad_tgt;

  assign take    = imem_valid &
                   ((state_q == S_FETCH) |
                    (state_q == S_WAIT));
  assign commit  = (state_q == S_ISSUE) & ~stall;
  assign bad_tgt = |pc_result[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: state_d = imem_valid ? S_ISSUE : S_WAIT;
      S_WAIT:  state_d = imem_valid ? S_ISSUE : S_WAIT;
      S_ISSUE: begin
        if (!stall) begin
          state_d = bad_tgt ? S_FAULT : S_FETCH;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
  end

  // A misaligned target still retires the faulting fetch but keeps the PC.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    if (take) begin
      instr_d = imem_rdata;
    end
    if (commit) begin
      cnt_d = cnt_q + 32'd1;
      if (bad_tgt) begin
        mis_d = 1'b1;
      end else begin
        pc_d = pc_result;
      end
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      S_FETCH: imem_req    = 1'b1;
      S_WAIT:  imem_req    = 1'b1;
      S_ISSUE: instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_4        = pc_q + 32'd4;
  assign instr       = instr_q;
  assign fetch_count = cnt_q;
  assign misaligned  = mis_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the single-cycle CPU datapath: owns the program counter and drives instruction memory. It issues a word fetch at the current PC, presents the instruction and `pc_4` to decode/execute, and waits for execute to return the next PC (`pc_result`: branch target, jr register, j target or `pc_4`). Before committing that next PC it checks alignment and counts retired fetches. This is the consumer end of the execute stage's `pc_result` and the producer of its `pc_4`.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `pc_result`  in  32  next PC from execute; sampled only in ISSUE with `stall`=0.
- `stall`  in  1  downstream hold; freezes ISSUE.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address of fetch, always equals `pc`.
- `imem_valid`  in  1  memory returns data this cycle; ignored when `imem_req`=0.
- `imem_rdata`  in  32  instruction word, valid with `imem_valid`.
- `instr`  out  32  registered instruction.
- `instr_valid`  out  1  `instr`/`pc_4` are valid for decode/execute.
- `pc`  out  32  current PC register.
- `pc_4`  out  32  `pc` + 4, combinational from `pc`.
- `fetch_count`  out  32  number of committed instructions.
- `misaligned`  out  1  sticky fault: execute returned `pc_result[1:0]` != 0.

## Operation
- States: BOOT, FETCH, WAIT, ISSUE, FAULT.
- BOOT: entered on reset. Outputs are idle. Always advances to FETCH on the next cycle.
- FETCH:
  - `imem_req`=1.
  - If `imem_valid`=1, capture `imem_rdata` into `instr` and go to ISSUE.
  - Otherwise go to WAIT.
- WAIT:
  - `imem_req` stays 1 and `imem_addr` stays stable.
  - On `imem_valid`=1, capture the data and go to ISSUE.
  - There is no timeout.
- ISSUE: `instr_valid`=1 and `imem_req`=0.
  - `stall`=1: hold the state. `pc`, `instr` and `fetch_count` are unchanged.
  - `stall`=0 and `pc_result[1:0]`==0: `pc` <= `pc_result`, `fetch_count` += 1, go to FETCH.
  - `stall`=0 and `pc_result[1:0]`!=0: `pc` is unchanged, `misaligned` <= 1, `fetch_count` += 1, go to FAULT.
- FAULT: `imem_req`=0 and `instr_valid`=0. Stays in FAULT until `rst`.
- `pc_4` is a 32-bit add, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- `fetch_count` wraps from 32'hFFFF_FFFF to 0.
- `imem_valid` outside FETCH/WAIT is ignored and does not change `instr`.

## Timing
- Reset values, at the edge with `rst`=1:
  - state=BOOT, `pc`=`RESET_PC`, `instr`=0, `fetch_count`=0, `misaligned`=0.
  - `imem_req`=0, `instr_valid`=0, `pc_4`=`RESET_PC`+4.
- `rst` overrides everything, including a pending WAIT: `imem_req` is 0 from the cycle after the reset edge, and a late `imem_valid` is dropped.
- First request is issued 2 cycles after `rst` deasserts (BOOT, then FETCH).
- Zero-wait memory (`imem_valid` in FETCH): `instr_valid` rises 1 cycle after FETCH. Steady-state throughput is 1 instruction per 2 cycles.
- N wait cycles add N cycles of latency.
- `instr_valid` and `instr` are registered. `imem_req` and `imem_addr` decode from state and `pc` only, with no combinational path from inputs.
- `pc_result` is sampled on the edge that leaves ISSUE. Execute must produce it combinationally from `instr`/`pc_4` within that cycle.

## Test plan
- Reset and boot: hold `rst` for 3 cycles, then release.
  - Required: `pc`=32'h3000 and `imem_req`=0 during BOOT.
  - Required: `imem_req`=1 with `imem_addr`=32'h3000 exactly 2 cycles after release.
- Sequential fetch with zero-wait memory: return `pc_result`=`pc_4` each time.
  - Required: `imem_addr` sequence 3000, 3004, 3008.
  - Required: `instr_valid` high every other cycle; `fetch_count`=3 after the third ISSUE.
- Wait states and stall:
  - Memory delays 3 cycles: `imem_addr` holds steady across WAIT, and `instr` equals the late `imem_rdata`.
  - `stall`=1 for 4 cycles in ISSUE: `pc`, `instr` and `fetch_count` are frozen, and `imem_req`=0.
- Branch/jump redirect: at `pc`=3010, return `pc_result`=32'h0000_3100.
  - Required: next `imem_addr`=3100; `pc_4` reads 3104 in the following ISSUE.
- Misaligned target: return `pc_result`=32'h0000_3102.
  - Required: `misaligned`=1 and `pc` stays 3010, with no further `imem_req`.
  - Required: after `rst`, `misaligned` clears and fetch restarts at 3000.
- Wrap and mid-wait reset:
  - `RESET_PC`=32'hFFFF_FFFC: `pc_4`=0, and `pc_result`=0 is fetched at address 0.
  - `rst` asserted during WAIT, with `imem_valid` arriving the next cycle: data is ignored, `instr`=0, and state restarts in BOOT.
